// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter in front of an NR_REQ:1 keyed data mux.
// The granted requester index is the mux key. The selected word is captured
// into a single-entry output stage that can be refilled on every cycle.
module rr_mux_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int DATA_LEN = 2,
  parameter int SEL_LEN  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  input  logic [NR_REQ*DATA_LEN-1:0]   req_data,
  output logic [NR_REQ-1:0]            req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_LEN-1:0]          out_data,
  output logic [SEL_LEN-1:0]           out_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_p0;
  logic [DATA_LEN-1:0]   data_p0;
  logic [SEL_LEN-1:0]    sel_p0;
  logic [SEL_LEN-1:0]    ptr;

  logic                  can_load;
  logic                  gnt_any;
  logic                  found;
  logic [SEL_LEN-1:0]    gnt_idx;
  logic [DATA_LEN-1:0]   gnt_data;
  logic                  xfer;

  // Scan from ptr upward with natural SEL_LEN-bit wrap; first valid wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!found && req_valid[ptr + SEL_LEN'(k)]) begin
        gnt_idx = ptr + SEL_LEN'(k);
        found   = 1'b1;
      end
    end
  end

  // Keyed mux: pick the granted requester's slice of the packed data bus.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (SEL_LEN'(k) == gnt_idx) begin
        gnt_data = req_data[k*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign gnt_any  = |req_valid;
  assign can_load = (state_p0 == EMPTY) | out_ready;

  // Ready is one-hot on the grant and forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && can_load && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Output stage FSM: load on a transfer, drain when the consumer takes the
  // word and nothing replaces it. ptr moves only when a word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= EMPTY;
      data_p0  <= '0;
      sel_p0   <= '0;
      ptr      <= '0;
    end else begin
      if (xfer) begin
        state_p0 <= FULL;
        data_p0  <= gnt_data;
        sel_p0   <= gnt_idx;
        ptr      <= gnt_idx + 1'b1;
      end else if (state_p0 == FULL && out_ready) begin
        state_p0 <= EMPTY;
      end
    end
  end

  assign out_valid = (state_p0 == FULL);
  assign out_data  = data_p0;
  assign out_sel   = sel_p0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (NR_REQ=4, DATA_LEN=2).
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data;
  logic [3:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [1:0] out_sel;

  int total = 0;
  int bad   = 0;

  rr_mux_arbiter #(.NR_REQ(4), .DATA_LEN(2), .SEL_LEN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, the expected combinational ready, and the
  // registered output contents visible during that cycle.
  typedef struct {
    logic [3:0] v;
    logic [7:0] d;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_sel;
    logic [1:0] e_dat;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // single requester 2 with data 2'b10
    vecs[0]  = '{4'b0100, 8'h20, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd0};
    vecs[1]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd2, 2'd2};
    vecs[2]  = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2};
    // all valid, data_i = i, ptr starts at 3
    vecs[3]  = '{4'b1111, 8'hE4, 1'b1, 4'b1000, 1'b0, 2'd2, 2'd2};
    vecs[4]  = '{4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 2'd3, 2'd3};
    vecs[5]  = '{4'b1111, 8'hE4, 1'b1, 4'b0010, 1'b1, 2'd0, 2'd0};
    vecs[6]  = '{4'b1111, 8'hE4, 1'b1, 4'b0100, 1'b1, 2'd1, 2'd1};
    vecs[7]  = '{4'b1111, 8'hE4, 1'b1, 4'b1000, 1'b1, 2'd2, 2'd2};
    // backpressure for three cycles
    vecs[8]  = '{4'b1111, 8'hE4, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd3};
    vecs[9]  = '{4'b1111, 8'hE4, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd3};
    vecs[10] = '{4'b1111, 8'hE4, 1'b0, 4'b0000, 1'b1, 2'd3, 2'd3};
    vecs[11] = '{4'b1111, 8'hE4, 1'b1, 4'b0001, 1'b1, 2'd3, 2'd3};
    // only req3 valid, scan from ptr=1 reaches it
    vecs[12] = '{4'b1000, 8'hE4, 1'b1, 4'b1000, 1'b1, 2'd0, 2'd0};
    // five idle cycles, ptr must stay wrapped at 0
    vecs[13] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd3, 2'd3};
    vecs[14] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
    vecs[15] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
    vecs[16] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
    vecs[17] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
    vecs[18] = '{4'b0011, 8'hE4, 1'b1, 4'b0001, 1'b0, 2'd3, 2'd3};
    vecs[19] = '{4'b0011, 8'hE4, 1'b1, 4'b0010, 1'b1, 2'd0, 2'd0};
    // ptr=2, only req0 valid: scan wraps to 0; req0 carries 2'b10
    vecs[20] = '{4'b0001, 8'h5A, 1'b1, 4'b0001, 1'b1, 2'd1, 2'd1};
    vecs[21] = '{4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 2'd0, 2'd2};
    vecs[22] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 2'd0, 2'd2};
    vecs[23] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd2};

    // reset held with every requester valid
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 8'hE4;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_sel",   32'(out_sel),   32'h0);
    chk("rst_data",  32'(out_data),  32'h0);
    rst = 1'b0;
    #1;
    chk("rst_first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req_valid = vecs[i].v;
      req_data  = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_sel", i),   32'(out_sel),   32'(vecs[i].e_sel));
      chk($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].e_dat));
    end

    // fill the stage from req1 (ptr becomes 2), then reset between edges
    @(negedge clk);
    req_valid = 4'b0011;
    req_data  = 8'hE4;
    out_ready = 1'b1;
    #1;
    chk("ar_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #1;
    chk("ar_full_valid", 32'(out_valid), 32'h1);
    chk("ar_full_sel",   32'(out_sel),   32'h1);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_sel",   32'(out_sel),   32'h0);
    chk("ar_data",  32'(out_data),  32'h0);
    chk("ar_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("ar_regrant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'h1);
    chk("ar_out_sel",   32'(out_sel),   32'h0);
    chk("ar_out_data",  32'(out_data),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
